// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Sequential front-end for the combinational ALU32Bit. Accepts one operation
//   request over a valid/ready handshake, decodes ALUOp/Funct into the 4-bit
//   ALUControl code, drives the ALU from registered operands, captures the ALU
//   result after one settle cycle and returns it over a second valid/ready
//   handshake. Undecodable requests are answered at once with IllegalOp set.
//   Completed legal operations are counted in OpCount, which wraps silently.
//
// Ports
//   Clk, Rst          rising-edge clock, synchronous active-low reset
//   InValid/InReady   request handshake
//   ALUOp, Funct      operation class and R-type function field
//   InA, InB          request operands
//   ALUControl, A, B  registered drive into ALU32Bit
//   ALUResult, Zero   combinational ALU32Bit outputs
//   OutValid/OutReady response handshake
//   OutResult, OutZero, OutCtrl, IllegalOp  captured response
//   OpCount           completed legal operations (COUNT_W bits)
module alu_issue_ctrl #(
   parameter int unsigned COUNT_W = 16
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               InValid,
   output logic               InReady,
   input  logic [1:0]         ALUOp,
   input  logic [5:0]         Funct,
   input  logic [31:0]        InA,
   input  logic [31:0]        InB,
   output logic [3:0]         ALUControl,
   output logic [31:0]        A,
   output logic [31:0]        B,
   input  logic [31:0]        ALUResult,
   input  logic               Zero,
   output logic               OutValid,
   input  logic               OutReady,
   output logic [31:0]        OutResult,
   output logic               OutZero,
   output logic [3:0]         OutCtrl,
   output logic               IllegalOp,
   output logic [COUNT_W-1:0] OpCount
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic                 w_accept;
   logic                 w_legal;
   logic [3:0]           w_dec_ctrl;

   logic [3:0]           r_alu_ctrl;
   logic [31:0]          r_a;
   logic [31:0]          r_b;
   logic                 r_out_valid;
   logic [31:0]          r_out_result;
   logic                 r_out_zero;
   logic [3:0]           r_out_ctrl;
   logic                 r_illegal;
   logic [COUNT_W-1:0]   r_count;

   // Decode of the request into the ALU32Bit control code
   always_comb begin
      w_legal    = 1'b1;
      w_dec_ctrl = 4'b0000;
      case (ALUOp)
         2'b00: w_dec_ctrl = 4'b0010;
         2'b01: w_dec_ctrl = 4'b0110;
         2'b10: begin
            case (Funct)
               6'b100000: w_dec_ctrl = 4'b0010;
               6'b100010: w_dec_ctrl = 4'b0110;
               6'b100100: w_dec_ctrl = 4'b0000;
               6'b100101: w_dec_ctrl = 4'b0001;
               6'b100111: w_dec_ctrl = 4'b1100;
               6'b101010: w_dec_ctrl = 4'b0111;
               default:   w_legal    = 1'b0;
            endcase
         end
         default: w_legal = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge Clk) begin
      if (!Rst) r_state <= S_IDLE;
      else      r_state <= w_next_state;
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next_state = w_legal ? S_EXEC : S_HOLD;
         S_EXEC: w_next_state = S_HOLD;
         S_HOLD: if (OutReady) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Output logic: ready only in IDLE and never while reset is asserted
   always_comb begin
      InReady  = (r_state == S_IDLE) && Rst;
      w_accept = InValid && InReady;
   end

   // Datapath and response registers
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         r_alu_ctrl   <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_out_zero   <= 1'b0;
         r_out_ctrl   <= '0;
         r_illegal    <= 1'b0;
         r_count      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_legal) begin
                     r_a        <= InA;
                     r_b        <= InB;
                     r_alu_ctrl <= w_dec_ctrl;
                  end else begin
                     // Illegal requests skip the ALU and respond immediately
                     r_out_result <= '0;
                     r_out_zero   <= 1'b0;
                     r_out_ctrl   <= '1;
                     r_illegal    <= 1'b1;
                     r_out_valid  <= 1'b1;
                  end
               end
            end
            S_EXEC: begin
               r_out_result <= ALUResult;
               r_out_zero   <= Zero;
               r_out_ctrl   <= r_alu_ctrl;
               r_illegal    <= 1'b0;
               r_out_valid  <= 1'b1;
            end
            S_HOLD: begin
               if (OutReady) begin
                  r_out_valid <= 1'b0;
                  if (!r_illegal) r_count <= r_count + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign ALUControl = r_alu_ctrl;
   assign A          = r_a;
   assign B          = r_b;
   assign OutValid   = r_out_valid;
   assign OutResult  = r_out_result;
   assign OutZero    = r_out_zero;
   assign OutCtrl    = r_out_ctrl;
   assign IllegalOp  = r_illegal;
   assign OpCount    = r_count;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        InValid;
   logic        InReady;
   logic [1:0]  ALUOp;
   logic [5:0]  Funct;
   logic [31:0] InA, InB;
   logic [3:0]  ALUControl;
   logic [31:0] A, B;
   logic [31:0] ALUResult;
   logic        Zero;
   logic        OutValid;
   logic        OutReady;
   logic [31:0] OutResult;
   logic        OutZero;
   logic [3:0]  OutCtrl;
   logic        IllegalOp;
   logic [3:0]  OpCount;

   alu_issue_ctrl #(.COUNT_W(4)) dut (
      .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
      .ALUOp(ALUOp), .Funct(Funct), .InA(InA), .InB(InB),
      .ALUControl(ALUControl), .A(A), .B(B),
      .ALUResult(ALUResult), .Zero(Zero),
      .OutValid(OutValid), .OutReady(OutReady), .OutResult(OutResult),
      .OutZero(OutZero), .OutCtrl(OutCtrl), .IllegalOp(IllegalOp),
      .OpCount(OpCount)
   );

   always #5 Clk = ~Clk;

   // Stand-in for the combinational ALU32Bit
   always_comb begin
      case (ALUControl)
         4'b0010: ALUResult = A + B;
         4'b0110: ALUResult = A - B;
         4'b0000: ALUResult = A & B;
         4'b0001: ALUResult = A | B;
         4'b1100: ALUResult = ~(A | B);
         4'b0111: ALUResult = {31'b0, ($signed(A) < $signed(B))};
         default: ALUResult = 32'hDEAD_BEEF;
      endcase
      Zero = (ALUResult == 32'd0);
   end

   typedef struct {
      string       name;
      logic [1:0]  aluop;
      logic [5:0]  funct;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_res;
      logic        exp_zero;
      logic [3:0]  exp_ctrl;
      logic        exp_ill;
   } vec_t;

   vec_t        vecs[11];
   int          n_total = 0;
   int          n_pass  = 0;
   logic [3:0]  exp_count = '0;
   logic [31:0] last_a = '0;
   logic [31:0] last_b = '0;
   logic [3:0]  last_ctrl = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic wait_ready();
      int w = 0;
      while (InReady !== 1'b1 && w < 10) begin
         @(posedge Clk); #1;
         w++;
      end
      check("wait_InReady", {31'b0, InReady}, 32'd1);
   endtask

   task automatic do_op(input vec_t v);
      wait_ready();
      ALUOp = v.aluop; Funct = v.funct; InA = v.a; InB = v.b; InValid = 1'b1;
      @(posedge Clk); #1;
      InValid = 1'b0;
      if (!v.exp_ill) begin
         check({v.name, "_exec_valid"}, {31'b0, OutValid}, 32'd0);
         check({v.name, "_ALUControl"}, {28'b0, ALUControl}, {28'b0, v.exp_ctrl});
         check({v.name, "_A"}, A, v.a);
         check({v.name, "_B"}, B, v.b);
         check({v.name, "_exec_ready"}, {31'b0, InReady}, 32'd0);
         last_a = v.a; last_b = v.b; last_ctrl = v.exp_ctrl;
         @(posedge Clk); #1;
      end else begin
         check({v.name, "_A_kept"}, A, last_a);
         check({v.name, "_ALUControl_kept"}, {28'b0, ALUControl}, {28'b0, last_ctrl});
      end
      check({v.name, "_OutValid"}, {31'b0, OutValid}, 32'd1);
      check({v.name, "_OutResult"}, OutResult, v.exp_res);
      check({v.name, "_OutZero"}, {31'b0, OutZero}, {31'b0, v.exp_zero});
      check({v.name, "_OutCtrl"}, {28'b0, OutCtrl}, {28'b0, v.exp_ctrl});
      check({v.name, "_IllegalOp"}, {31'b0, IllegalOp}, {31'b0, v.exp_ill});
      check({v.name, "_hold_ready"}, {31'b0, InReady}, 32'd0);
      @(posedge Clk); #1;
      if (!v.exp_ill) exp_count = exp_count + 1'b1;
      check({v.name, "_done_valid"}, {31'b0, OutValid}, 32'd0);
      check({v.name, "_OpCount"}, {28'b0, OpCount}, {28'b0, exp_count});
   endtask

   initial begin
      vecs[0]  = '{"add",     2'b10, 6'b100000, 32'd5, 32'd10, 32'd15, 1'b0, 4'b0010, 1'b0};
      vecs[1]  = '{"sub_op",  2'b01, 6'b000000, 32'd5, 32'd5, 32'd0, 1'b1, 4'b0110, 1'b0};
      vecs[2]  = '{"slt_t",   2'b10, 6'b101010, 32'd3, 32'd7, 32'd1, 1'b0, 4'b0111, 1'b0};
      vecs[3]  = '{"slt_f",   2'b10, 6'b101010, 32'd9, 32'd2, 32'd0, 1'b1, 4'b0111, 1'b0};
      vecs[4]  = '{"nor",     2'b10, 6'b100111, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0000F0F0, 1'b0, 4'b1100, 1'b0};
      vecs[5]  = '{"and",     2'b10, 6'b100100, 32'd5, 32'd10, 32'd0, 1'b1, 4'b0000, 1'b0};
      vecs[6]  = '{"or",      2'b10, 6'b100101, 32'd5, 32'd10, 32'd15, 1'b0, 4'b0001, 1'b0};
      vecs[7]  = '{"ill_fn",  2'b10, 6'b000000, 32'd1, 32'd2, 32'd0, 1'b0, 4'b1111, 1'b1};
      vecs[8]  = '{"ill_op",  2'b11, 6'b100000, 32'd3, 32'd4, 32'd0, 1'b0, 4'b1111, 1'b1};
      vecs[9]  = '{"add_op",  2'b00, 6'b111111, 32'd7, 32'd8, 32'd15, 1'b0, 4'b0010, 1'b0};
      vecs[10] = '{"sub_neg", 2'b10, 6'b100010, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0, 4'b0110, 1'b0};

      Rst = 1'b0; InValid = 1'b0; OutReady = 1'b1;
      ALUOp = '0; Funct = '0; InA = '0; InB = '0;
      @(posedge Clk); #1;
      check("rst_InReady", {31'b0, InReady}, 32'd0);
      @(posedge Clk); #1;
      check("rst_OutValid", {31'b0, OutValid}, 32'd0);
      check("rst_OpCount", {28'b0, OpCount}, 32'd0);
      check("rst_A", A, 32'd0);
      check("rst_OutCtrl", {28'b0, OutCtrl}, 32'd0);
      Rst = 1'b1;
      @(posedge Clk); #1;
      check("idle_InReady", {31'b0, InReady}, 32'd1);

      // Two passes so the 4-bit counter wraps past all-ones
      for (int pass = 0; pass < 2; pass++)
         for (int i = 0; i < 11; i++) do_op(vecs[i]);

      // Backpressure: response held, extra request ignored
      wait_ready();
      OutReady = 1'b0;
      ALUOp = 2'b00; InA = 32'd1; InB = 32'd2; InValid = 1'b1;
      @(posedge Clk); #1;
      InValid = 1'b0;
      @(posedge Clk); #1;
      for (int c = 0; c < 5; c++) begin
         check("bp_OutValid", {31'b0, OutValid}, 32'd1);
         check("bp_OutResult", OutResult, 32'd3);
         check("bp_OutCtrl", {28'b0, OutCtrl}, 32'h2);
         check("bp_InReady", {31'b0, InReady}, 32'd0);
         InValid = (c == 2);
         ALUOp = 2'b01; InA = 32'd100; InB = 32'd1;
         @(posedge Clk); #1;
      end
      InValid = 1'b0;
      check("bp_A_kept", A, 32'd1);
      OutReady = 1'b1;
      @(posedge Clk); #1;
      exp_count = exp_count + 1'b1;
      check("bp_release_valid", {31'b0, OutValid}, 32'd0);
      check("bp_OpCount", {28'b0, OpCount}, {28'b0, exp_count});
      check("bp_idle_ready", {31'b0, InReady}, 32'd1);
      @(posedge Clk); #1;
      check("bp_no_queued", {31'b0, OutValid}, 32'd0);
      check("bp_no_queued_A", A, 32'd1);

      // Reset during EXEC abandons the request
      wait_ready();
      ALUOp = 2'b00; InA = 32'd20; InB = 32'd22; InValid = 1'b1;
      @(posedge Clk); #1;
      InValid = 1'b0;
      Rst = 1'b0;
      @(posedge Clk); #1;
      check("rstx_OutValid", {31'b0, OutValid}, 32'd0);
      check("rstx_A", A, 32'd0);
      check("rstx_B", B, 32'd0);
      check("rstx_ALUControl", {28'b0, ALUControl}, 32'd0);
      check("rstx_OpCount", {28'b0, OpCount}, 32'd0);
      check("rstx_InReady", {31'b0, InReady}, 32'd0);
      Rst = 1'b1;
      exp_count = '0; last_a = '0; last_b = '0; last_ctrl = '0;
      for (int c = 0; c < 3; c++) begin
         @(posedge Clk); #1;
         check("rstx_no_valid", {31'b0, OutValid}, 32'd0);
      end
      do_op(vecs[0]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule
